rx_reset_sequencer: RTL and testbench

- Central controller for receiver resets in the OFDM RX chain.
- Collects abort requests from the watchdog sources (DC/sign-balance, signal length, equalizer monitor, and others), adds an internal "stuck receiver" timeout, and arbitrates them by fixed priority.
- Issues a shaped `receiver_rst` pulse followed by a holdoff window.
- Latches the winning cause and keeps per-cause saturating event counters for debug register readout.

---
 rtl/rx_reset_sequencer.sv | 178 +++++++++++++++++
 tb/tb_rx_reset_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_reset_sequencer.sv
// Receiver reset controller: arbitrates masked watchdog requests plus a stuck-receiver timeout, shapes receiver_rst.
// Latency: a request sampled at edge N drives receiver_rst high after edge N; counter readouts lag by one cycle.
// No backpressure: requests or timeouts arriving during a reset pulse or its holdoff window are dropped.
module rx_reset_sequencer #(
  parameter int NUM_SRC       = 4,
  parameter int CNT_WIDTH     = 16,
  parameter int TIMEOUT_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC-1:0]       src_mask,
  input  logic                     power_trigger,
  input  logic                     rx_progress,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_th,
  input  logic [3:0]               rst_hold_len,
  input  logic [7:0]               holdoff_len,
  input  logic                     cnt_clear,
  input  logic [2:0]               cnt_sel,
  output logic                     receiver_rst,
  output logic [2:0]               rst_cause,
  output logic                     rst_cause_valid,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     cnt_out,
  output logic [CNT_WIDTH-1:0]     total_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  // Cause index NUM_SRC is the internal timeout; 7 means no cause latched yet.
  localparam logic [2:0] CAUSE_TMO  = 3'(NUM_SRC);
  localparam logic [2:0] CAUSE_NONE = 3'd7;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [7:0]               r_left;
  logic [7:0]               w_left_nxt;
  logic [7:0]               w_hold_m1;
  logic [TIMEOUT_WIDTH-1:0] r_tcnt;
  logic                     w_qual;
  logic                     w_tmo_req;
  logic                     w_fire;
  logic                     w_start;
  logic [NUM_SRC-1:0]       w_eff_req;
  logic [2:0]               w_winner;
  logic                     r_rx_rst;
  logic                     r_busy;
  logic                     r_cause_vld;
  logic [2:0]               r_cause;
  logic [CNT_WIDTH-1:0]     r_cnt [NUM_SRC+1];
  logic [CNT_WIDTH-1:0]     r_total;
  logic [CNT_WIDTH-1:0]     r_cnt_out;
  logic [CNT_WIDTH-1:0]     r_total_out;

  // Requests and the timeout only count inside an enabled packet-detect window.
  assign w_qual    = enable & power_trigger;
  assign w_eff_req = w_qual ? (src_req & src_mask) : '0;
  assign w_tmo_req = (timeout_th != '0) && (r_tcnt == timeout_th - TIMEOUT_WIDTH'(1));
  assign w_fire    = (r_state == S_IDLE) && ((|w_eff_req) || (w_qual && w_tmo_req));
  assign w_start   = (r_state == S_IDLE) && (w_state_nxt == S_ASSERT);

  // A programmed hold of 0 still yields a one-cycle pulse; r_left counts remaining cycles minus one.
  assign w_hold_m1 = (rst_hold_len == 4'd0) ? 8'd0 : {4'd0, rst_hold_len - 4'd1};

  // Fixed priority: lowest set request bit wins, the timeout only when no request is present.
  always_comb begin
    w_winner = CAUSE_TMO;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_eff_req[i]) w_winner = 3'(i);
    end
  end

  // Stuck-receiver timer: runs only while idle in the window; any clear condition beats the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (rx_progress || !power_trigger || (r_state != S_IDLE)) begin
      r_tcnt <= '0;
    end else if (enable) begin
      r_tcnt <= r_tcnt + TIMEOUT_WIDTH'(1);
    end
  end

  // Next-state logic: pulse length sampled on ASSERT entry, holdoff length on HOLDOFF entry.
  always_comb begin
    w_state_nxt = r_state;
    w_left_nxt  = r_left;
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_state_nxt = S_ASSERT;
          w_left_nxt  = w_hold_m1;
        end
      end
      S_ASSERT: begin
        if (r_left == 8'd0) begin
          if (holdoff_len != 8'd0) begin
            w_state_nxt = S_HOLDOFF;
            w_left_nxt  = holdoff_len - 8'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_left_nxt = r_left - 8'd1;
        end
      end
      S_HOLDOFF: begin
        if (r_left == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_left_nxt = r_left - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_left_nxt  = 8'd0;
      end
    endcase
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_left_nxt  = 8'd0;
    end
  end

  // State register and outputs registered from the next state so receiver_rst is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_left      <= 8'd0;
      r_rx_rst    <= 1'b0;
      r_busy      <= 1'b0;
      r_cause_vld <= 1'b0;
      r_cause     <= CAUSE_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_left      <= w_left_nxt;
      r_rx_rst    <= (w_state_nxt == S_ASSERT);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_cause_vld <= w_start;
      if (w_start) r_cause <= w_winner;
    end
  end

  // Saturating per-cause and total event counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      for (int i = 0; i <= NUM_SRC; i++) r_cnt[i] <= '0;
      r_total <= '0;
    end else if (w_start) begin
      if (r_cnt[w_winner] != '1) r_cnt[w_winner] <= r_cnt[w_winner] + CNT_WIDTH'(1);
      if (r_total != '1) r_total <= r_total + CNT_WIDTH'(1);
    end
  end

  // Registered debug readout; out-of-range selects read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_out   <= '0;
      r_total_out <= '0;
    end else begin
      r_cnt_out   <= (cnt_sel <= CAUSE_TMO) ? r_cnt[cnt_sel] : '0;
      r_total_out <= r_total;
    end
  end

  assign receiver_rst    = r_rx_rst;
  assign busy            = r_busy;
  assign rst_cause_valid = r_cause_vld;
  assign rst_cause       = r_cause;
  assign cnt_out         = r_cnt_out;
  assign total_cnt       = r_total_out;

endmodule

// File: tb/tb_rx_reset_sequencer.sv
// Bench for rx_reset_sequencer: timestamp-based reference model checked every cycle,
// a table of arbitration vectors, and directed sequences for the multi-cycle corners.
// Counter width is reduced to 4 bits so saturation is reachable in a short run.
module tb_rx_reset_sequencer;
  localparam int NS   = 4;
  localparam int CW   = 4;
  localparam int TW   = 20;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, enable, power_trigger, rx_progress, cnt_clear;
  logic [NS-1:0] src_req, src_mask;
  logic [TW-1:0] timeout_th;
  logic [3:0]    rst_hold_len;
  logic [7:0]    holdoff_len;
  logic [2:0]    cnt_sel;
  logic          receiver_rst, rst_cause_valid, busy;
  logic [2:0]    rst_cause;
  logic [CW-1:0] cnt_out, total_cnt;

  always #5 clk = ~clk;

  rx_reset_sequencer #(.NUM_SRC(NS), .CNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .src_req(src_req), .src_mask(src_mask),
    .power_trigger(power_trigger), .rx_progress(rx_progress), .timeout_th(timeout_th),
    .rst_hold_len(rst_hold_len), .holdoff_len(holdoff_len), .cnt_clear(cnt_clear),
    .cnt_sel(cnt_sel), .receiver_rst(receiver_rst), .rst_cause(rst_cause),
    .rst_cause_valid(rst_cause_valid), .busy(busy), .cnt_out(cnt_out), .total_cnt(total_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: cycle c follows edge c-1. A sequence started at edge s keeps
  // receiver_rst high through cycle rst_until and busy through cycle busy_until.
  int e          = 0;
  int rst_until  = -1;
  int busy_until = -1;
  int last_clear = 0;   // timeout fires at the edge where e - last_clear == timeout_th
  int m_cause    = 7;
  int m_valid    = 0;
  int m_cnt [NS+1];
  int m_total    = 0;
  int x_cnt_out  = 0;
  int x_total    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, e, act, exp);
    end
  endtask

  task automatic model_edge();
    bit idle, qual, tmo, start;
    int eff, win, h;
    e++;
    if (rst) begin
      rst_until = -1; busy_until = -1; last_clear = e;
      m_cause = 7; m_valid = 0; m_total = 0; x_cnt_out = 0; x_total = 0;
      for (int i = 0; i <= NS; i++) m_cnt[i] = 0;
      return;
    end
    idle  = (e > busy_until);
    qual  = enable && power_trigger;
    eff   = qual ? int'(src_req & src_mask) : 0;
    tmo   = qual && (timeout_th != 0) && ((e - last_clear) == int'(timeout_th));
    x_cnt_out = (int'(cnt_sel) <= NS) ? m_cnt[int'(cnt_sel)] : 0;
    x_total   = m_total;
    start = idle && ((eff != 0) || tmo);
    win = NS;
    for (int i = NS - 1; i >= 0; i--) if (((eff >> i) & 1) != 0) win = i;
    m_valid = start ? 1 : 0;
    if (start) m_cause = win;
    if (cnt_clear) begin
      for (int i = 0; i <= NS; i++) m_cnt[i] = 0;
      m_total = 0;
    end else if (start) begin
      if (m_cnt[win] < CMAX) m_cnt[win]++;
      if (m_total < CMAX) m_total++;
    end
    if (rx_progress || !power_trigger || !idle) last_clear = e;
    else if (!enable) last_clear++;
    // Last pulse cycle: holdoff length is taken here.
    if (!idle && e == rst_until) busy_until = e + int'(holdoff_len);
    if (start) begin
      h = (rst_hold_len == 0) ? 1 : int'(rst_hold_len);
      rst_until  = e + h;
      busy_until = e + h;
    end
    if (!enable) begin
      if (rst_until > e) rst_until = e;
      if (busy_until > e) busy_until = e;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_receiver_rst", int'(receiver_rst), (e + 1 <= rst_until) ? 1 : 0);
    chk("m_busy", int'(busy), (e + 1 <= busy_until) ? 1 : 0);
    chk("m_rst_cause", int'(rst_cause), m_cause);
    chk("m_cause_valid", int'(rst_cause_valid), m_valid);
    chk("m_cnt_out", int'(cnt_out), x_cnt_out);
    chk("m_total_cnt", int'(total_cnt), x_total);
  endtask

  typedef struct {
    logic [NS-1:0] req;
    logic [NS-1:0] mask;
    int            cause;
  } vec_t;

  vec_t vt [6];
  int   exp_hits [NS+1];
  int   n_rst, n_busy, n_vld, first, found, rises, second, prev;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "bench time limit");
  end

  initial begin
    vt[0] = '{4'b1010, 4'b1111, 1};
    vt[1] = '{4'b1010, 4'b1101, 3};
    vt[2] = '{4'b0001, 4'b1111, 0};
    vt[3] = '{4'b1111, 4'b1110, 1};
    vt[4] = '{4'b1100, 4'b0111, 2};
    vt[5] = '{4'b1000, 4'b1111, 3};
    for (int i = 0; i <= NS; i++) begin m_cnt[i] = 0; exp_hits[i] = 0; end

    rst = 1; enable = 0; power_trigger = 0; rx_progress = 0; cnt_clear = 0;
    src_req = '0; src_mask = '1; timeout_th = '0; rst_hold_len = 4'd1;
    holdoff_len = 8'd0; cnt_sel = 3'd0;
    repeat (3) step();
    chk("reset_rst", int'(receiver_rst), 0);
    chk("reset_cause", int'(rst_cause), 7);
    chk("reset_valid", int'(rst_cause_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_total", int'(total_cnt), 0);
    rst = 0; enable = 1; power_trigger = 1;
    step();

    // Single request: 3-cycle pulse then 5 cycles of holdoff.
    rst_hold_len = 4'd3; holdoff_len = 8'd5; cnt_sel = 3'd2; src_req = 4'b0100;
    n_rst = 0; n_busy = 0; n_vld = 0; first = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) src_req = '0;
      if (receiver_rst) begin n_rst++; if (first == 0) first = k; end
      if (busy) n_busy++;
      if (rst_cause_valid) n_vld++;
    end
    chk("t1_first_rst", first, 1);
    chk("t1_rst_cycles", n_rst, 3);
    chk("t1_busy_cycles", n_busy, 8);
    chk("t1_valid_pulses", n_vld, 1);
    chk("t1_cause", int'(rst_cause), 2);
    chk("t1_cnt2", int'(cnt_out), 1);
    chk("t1_total", int'(total_cnt), 1);

    // Arbitration table.
    rst_hold_len = 4'd1; holdoff_len = 8'd0; cnt_clear = 1; step(); cnt_clear = 0;
    foreach (vt[i]) begin
      src_req = vt[i].req; src_mask = vt[i].mask;
      step();
      chk("vec_valid", int'(rst_cause_valid), 1);
      chk("vec_cause", int'(rst_cause), vt[i].cause);
      chk("vec_rst", int'(receiver_rst), 1);
      exp_hits[vt[i].cause]++;
      src_req = '0;
      repeat (2) step();
    end
    src_mask = '1;
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s);
      step();
      if (s <= NS) chk("vec_cnt_sel", int'(cnt_out), exp_hits[s]);
      else chk("vec_cnt_oob", int'(cnt_out), 0);
    end
    chk("vec_total", int'(total_cnt), 6);

    // Stuck-receiver timeout: 100 edges after the window opens (101 counting the rise edge).
    power_trigger = 0; timeout_th = TW'(100); repeat (2) step();
    power_trigger = 1; found = 0;
    for (int k = 1; k <= 200 && found == 0; k++) begin
      step();
      if (receiver_rst) found = k;
    end
    chk("t3_timeout_latency", found, 100);
    chk("t3_timeout_cause", int'(rst_cause), NS);
    power_trigger = 0; repeat (3) step();
    power_trigger = 1; n_rst = 0;
    for (int k = 0; k < 300; k++) begin
      rx_progress = (k % 50 == 0);
      step();
      if (receiver_rst) n_rst++;
    end
    rx_progress = 0;
    chk("t3_progress_no_rst", n_rst, 0);
    power_trigger = 0; step();
    timeout_th = '0; power_trigger = 1; n_rst = 0;
    for (int k = 0; k < 300; k++) begin step(); if (receiver_rst) n_rst++; end
    chk("t3_th0_no_rst", n_rst, 0);

    // Request during holdoff is dropped.
    rst_hold_len = 4'd3; holdoff_len = 8'd5; cnt_sel = 3'd1;
    cnt_clear = 1; step(); cnt_clear = 0;
    src_req = 4'b0001; step(); src_req = '0;
    repeat (4) step();
    src_req = 4'b0010; step(); src_req = '0;
    n_rst = 0;
    for (int k = 0; k < 10; k++) begin step(); if (receiver_rst) n_rst++; end
    chk("t4_holdoff_drop_rst", n_rst, 0);
    chk("t4_holdoff_cnt1", int'(cnt_out), 0);
    chk("t4_holdoff_total", int'(total_cnt), 1);
    chk("t4_holdoff_cause", int'(rst_cause), 0);

    // Held level request retriggers on the first idle cycle.
    cnt_clear = 1; step(); cnt_clear = 0;
    src_req = 4'b0100; rises = 0; second = 0; prev = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (receiver_rst && prev == 0) begin rises++; if (rises == 2) second = k; end
      prev = int'(receiver_rst);
    end
    src_req = '0; repeat (14) step();
    chk("t4_held_rises", rises, 2);
    chk("t4_held_second_at", second, 10);
    chk("t4_held_total", int'(total_cnt), 2);

    // Enable dropped in the 2nd ASSERT cycle.
    rst_hold_len = 4'd8; holdoff_len = 8'd5; src_req = 4'b0010;
    step(); src_req = '0; step();
    enable = 0; step();
    chk("t5_en_rst", int'(receiver_rst), 0);
    chk("t5_en_busy", int'(busy), 0);
    chk("t5_en_cause", int'(rst_cause), 1);
    enable = 1; repeat (3) step();
    chk("t5_idle_busy", int'(busy), 0);
    power_trigger = 0; src_req = 4'b1111; n_rst = 0;
    for (int k = 0; k < 10; k++) begin step(); if (receiver_rst) n_rst++; end
    chk("t5_no_window_rst", n_rst, 0);
    src_req = '0; power_trigger = 1;

    // Saturation, clear-vs-increment, reset in mid-pulse.
    rst_hold_len = 4'd1; holdoff_len = 8'd0; cnt_sel = 3'd0;
    cnt_clear = 1; step(); cnt_clear = 0;
    for (int k = 0; k < CMAX; k++) begin src_req = 4'b0001; step(); src_req = '0; repeat (2) step(); end
    step();
    chk("t6_cnt0_full", int'(cnt_out), CMAX);
    chk("t6_total_full", int'(total_cnt), CMAX);
    src_req = 4'b0001; step(); src_req = '0; repeat (3) step();
    chk("t6_cnt0_sat", int'(cnt_out), CMAX);
    chk("t6_total_sat", int'(total_cnt), CMAX);
    src_req = 4'b0001; cnt_clear = 1; step(); src_req = '0; cnt_clear = 0;
    chk("t6_clr_seq_rst", int'(receiver_rst), 1);
    repeat (3) step();
    chk("t6_clr_cnt0", int'(cnt_out), 0);
    chk("t6_clr_total", int'(total_cnt), 0);
    rst_hold_len = 4'd8; src_req = 4'b0100; step(); src_req = '0; step();
    rst = 1; step();
    chk("t6_rst_rx", int'(receiver_rst), 0);
    chk("t6_rst_cause", int'(rst_cause), 7);
    chk("t6_rst_busy", int'(busy), 0);
    rst = 0; step();

    // Randomized traffic against the model.
    timeout_th = TW'(25);
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 19) == 0) power_trigger = ~power_trigger;
      src_req = ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0;
      if ($urandom_range(0, 39) == 0) src_mask = NS'($urandom);
      rx_progress = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) timeout_th = TW'($urandom_range(0, 40));
      rst_hold_len = 4'($urandom_range(0, 4));
      holdoff_len = 8'($urandom_range(0, 6));
      cnt_clear = ($urandom_range(0, 49) == 0);
      cnt_sel = 3'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
